// File: rtl/ibex_cheri_pkg.sv
// Shared CHERI tag definitions: granule geometry, tag region base and tag controller states.
package ibex_cheri_pkg;

  localparam int unsigned CAP_BYTES_LOG2 = 3;
  localparam logic [31:0] TAG_BASE_ADDR  = 32'h0010_0000;

  typedef enum logic [1:0] {
    TAG_IDLE  = 2'd0,
    TAG_RESP  = 2'd1,
    TAG_CLEAR = 2'd2
  } tag_ctrl_state_e;

endpackage

// File: rtl/ibex_cheri_tag_ctrl.sv
// Tag memory controller: maps LSU tag accesses onto the tag memory and sweeps
// index ranges to zero on request. One request outstanding, one per cycle.
module ibex_cheri_tag_ctrl
  import ibex_cheri_pkg::tag_ctrl_state_e;
  import ibex_cheri_pkg::TAG_IDLE;
  import ibex_cheri_pkg::TAG_RESP;
  import ibex_cheri_pkg::TAG_CLEAR;
#(
  parameter int unsigned TAG_MEM_SIZE   = 4096,
  parameter logic [31:0] TAG_BASE_ADDR  = ibex_cheri_pkg::TAG_BASE_ADDR,
  parameter int unsigned CAP_BYTES_LOG2 = ibex_cheri_pkg::CAP_BYTES_LOG2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tag_req_i,
  output logic        tag_gnt_o,
  input  logic        tag_we_i,
  input  logic [31:0] tag_addr_i,
  input  logic        tag_wdata_i,
  output logic        tag_rvalid_o,
  output logic        tag_rdata_o,
  output logic        tag_err_o,
  input  logic        clear_start_i,
  input  logic [31:0] clear_lo_i,
  input  logic [31:0] clear_hi_i,
  output logic        clear_busy_o,
  output logic        clear_done_o,
  output logic [31:0] tmem_addr_o,
  output logic        tmem_we_o,
  output logic        tmem_wdata_o,
  input  logic        tmem_rdata_i
);

  localparam logic [31:0] LAST_IDX = 32'(TAG_MEM_SIZE - 1);

  // Handshake: a request is granted in the cycle tag_req_i && tag_gnt_o; its
  // single response (tag_rvalid_o) follows exactly one cycle later, in order.
  tag_ctrl_state_e state;
  logic [31:0]     clr_idx;
  logic [31:0]     clr_hi;
  logic            rvalid_q;
  logic            err_q;
  logic            rd_q;
  logic            done_q;

  logic [31:0] offset;
  logic [31:0] index;
  logic        in_range;
  logic        clear_accept;
  logic        grant;
  logic        sweep_wr;
  logic        sweep_end;

  always_comb begin
    offset   = tag_addr_i - TAG_BASE_ADDR;
    index    = offset >> CAP_BYTES_LOG2;
    in_range = (tag_addr_i >= TAG_BASE_ADDR) && (index < 32'(TAG_MEM_SIZE));
    // In IDLE a clear wins over a request; in RESP a request wins over a clear.
    clear_accept = rst_ni && clear_start_i &&
                   ((state == TAG_IDLE) || ((state == TAG_RESP) && !tag_req_i));
    grant     = rst_ni && tag_req_i && (state != TAG_CLEAR) && !clear_accept;
    sweep_wr  = rst_ni && (state == TAG_CLEAR) && (clr_idx <= clr_hi);
    sweep_end = (clr_idx >= clr_hi);
  end

  always_comb begin
    tmem_addr_o  = '0;
    tmem_we_o    = 1'b0;
    tmem_wdata_o = 1'b0;
    if (grant && in_range) begin
      tmem_addr_o  = index;
      tmem_we_o    = tag_we_i;
      tmem_wdata_o = tag_wdata_i;
    end else if (sweep_wr) begin
      tmem_addr_o  = clr_idx;
      tmem_we_o    = 1'b1;
      tmem_wdata_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= TAG_IDLE;
      clr_idx  <= '0;
      clr_hi   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= grant;
      err_q    <= grant && !in_range;
      rd_q     <= grant && in_range && !tag_we_i;
      done_q   <= 1'b0;
      case (state)
        TAG_IDLE, TAG_RESP: begin
          if (clear_accept) begin
            state   <= TAG_CLEAR;
            clr_idx <= clear_lo_i;
            clr_hi  <= (clear_hi_i > LAST_IDX) ? LAST_IDX : clear_hi_i;
          end else if (grant) begin
            state <= TAG_RESP;
          end else begin
            state <= TAG_IDLE;
          end
        end
        TAG_CLEAR: begin
          // Covers both the final write and an empty range (lo above hi).
          if (sweep_end) begin
            state  <= TAG_IDLE;
            done_q <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 32'd1;
          end
        end
        default: state <= TAG_IDLE;
      endcase
    end
  end

  assign tag_gnt_o    = grant;
  assign tag_rvalid_o = rvalid_q;
  assign tag_err_o    = err_q;
  assign tag_rdata_o  = rd_q & tmem_rdata_i;
  assign clear_busy_o = (state == TAG_CLEAR);
  assign clear_done_o = done_q;

endmodule

// File: tb/tb_ibex_cheri_tag_ctrl.sv
// Bench for ibex_cheri_tag_ctrl with a behavioural tag memory and reference model.
module tb_ibex_cheri_tag_ctrl;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          SIZE = 4096;

  logic        clk;
  logic        rst_n;
  logic        tag_req;
  logic        tag_gnt;
  logic        tag_we;
  logic [31:0] tag_addr;
  logic        tag_wdata;
  logic        tag_rvalid;
  logic        tag_rdata;
  logic        tag_err;
  logic        clear_start;
  logic [31:0] clear_lo;
  logic [31:0] clear_hi;
  logic        clear_busy;
  logic        clear_done;
  logic [31:0] tmem_addr;
  logic        tmem_we;
  logic        tmem_wdata;
  logic        tmem_rdata;

  ibex_cheri_tag_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tag_req_i    (tag_req),
    .tag_gnt_o    (tag_gnt),
    .tag_we_i     (tag_we),
    .tag_addr_i   (tag_addr),
    .tag_wdata_i  (tag_wdata),
    .tag_rvalid_o (tag_rvalid),
    .tag_rdata_o  (tag_rdata),
    .tag_err_o    (tag_err),
    .clear_start_i(clear_start),
    .clear_lo_i   (clear_lo),
    .clear_hi_i   (clear_hi),
    .clear_busy_o (clear_busy),
    .clear_done_o (clear_done),
    .tmem_addr_o  (tmem_addr),
    .tmem_we_o    (tmem_we),
    .tmem_wdata_o (tmem_wdata),
    .tmem_rdata_i (tmem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tag memory: one-cycle read latency
  logic tag_mem [SIZE];
  always @(posedge clk) begin
    if (tmem_we) tag_mem[tmem_addr[11:0]] <= tmem_wdata;
    tmem_rdata <= tag_mem[tmem_addr[11:0]];
  end

  // Scoreboard
  int n_pass = 0;
  int n_total = 0;
  logic model_mem [SIZE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        wdata;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        exp_rdata;
  } vec_t;
  vec_t vecs[10];

  int wr_q[$];

  // Drives a clear in the current cycle (caller is just past a negedge) and
  // checks the sweep against the range rules.
  task automatic run_clear(input logic [31:0] lo, input logic [31:0] hi, input logic hold_req);
    int done_at, busy_cnt, gnt_bad, n, hi_c, seq_bad, exp_done;
    wr_q.delete();
    done_at = -1; busy_cnt = 0; gnt_bad = 0; seq_bad = 0;
    clear_start = 1'b1; clear_lo = lo; clear_hi = hi;
    tag_req = hold_req; tag_we = 1'b0; tag_addr = BASE + 32'd40;
    #1 check("clr_accept_gnt", {31'd0, tag_gnt}, 32'd0);
    for (int c = 1; c < 6000 && done_at < 0; c++) begin
      @(negedge clk);
      clear_start = 1'b0;
      #1;
      if (clear_busy) busy_cnt++;
      if (tmem_we) begin
        wr_q.push_back(int'(tmem_addr));
        if (tmem_wdata) seq_bad++;
      end
      if (clear_done) begin
        done_at = c;
        check("clr_gnt_at_done", {31'd0, tag_gnt}, {31'd0, hold_req});
        tag_req = 1'b0;
      end else if (tag_gnt) gnt_bad++;
    end
    tag_req = 1'b0;
    hi_c = (hi > 32'(SIZE - 1)) ? SIZE - 1 : int'(hi);
    n = (hi_c >= int'(lo)) ? hi_c - int'(lo) + 1 : 0;
    exp_done = (n == 0) ? 2 : n + 1;
    check("clr_done_cycle", done_at, exp_done);
    check("clr_write_count", wr_q.size(), n);
    for (int k = 0; k < wr_q.size(); k++)
      if (wr_q[k] != int'(lo) + k) seq_bad++;
    check("clr_write_seq", seq_bad, 0);
    check("clr_gnt_in_clear", gnt_bad, 0);
    if (n > 0) check("clr_busy_cycles", busy_cnt, n);
    for (int k = int'(lo); k <= hi_c; k++) model_mem[k] = 1'b0;
  endtask

  initial begin
    int bad, mis, r;
    logic exp_pend, exp_err, exp_rd, in_r;
    logic [31:0] idx;

    for (int i = 0; i < SIZE; i++) begin
      tag_mem[i] = 1'b0;
      model_mem[i] = 1'b0;
    end
    rst_n = 1'b0; tag_req = 1'b0; tag_we = 1'b0; tag_addr = '0; tag_wdata = 1'b0;
    clear_start = 1'b0; clear_lo = '0; clear_hi = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", {31'd0, tag_gnt}, 0);
    check("rst_rvalid", {31'd0, tag_rvalid}, 0);
    check("rst_rdata", {31'd0, tag_rdata}, 0);
    check("rst_err", {31'd0, tag_err}, 0);
    check("rst_busy", {31'd0, clear_busy}, 0);
    check("rst_done", {31'd0, clear_done}, 0);
    check("rst_tmem_we", {31'd0, tmem_we}, 0);
    check("rst_tmem_wdata", {31'd0, tmem_wdata}, 0);
    check("rst_tmem_addr", tmem_addr, 0);
    rst_n = 1'b1;

    // Single-request vectors
    tag_mem[2] = 1'b1;
    vecs[0] = '{1'b0, 32'h0010_0010, 1'b0, 1'b0, 32'd2,    1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h0010_0008, 1'b1, 1'b1, 32'd1,    1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0010_0008, 1'b0, 1'b0, 32'd1,    1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h000F_FFF8, 1'b1, 1'b0, 32'd0,    1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h0010_8000, 1'b1, 1'b0, 32'd0,    1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0010_7FF8, 1'b0, 1'b0, 32'd4095, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h0010_7FF8, 1'b1, 1'b1, 32'd4095, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0010_7FF8, 1'b0, 1'b0, 32'd4095, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h0010_0014, 1'b0, 1'b0, 32'd2,    1'b0, 1'b1};
    vecs[9] = '{1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tag_req = 1'b1; tag_we = vecs[i].we; tag_addr = vecs[i].addr; tag_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_gnt", i), {31'd0, tag_gnt}, 1);
      check($sformatf("vec%0d_tmem_we", i), {31'd0, tmem_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_tmem_addr", i), tmem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_tmem_wdata", i), {31'd0, tmem_wdata},
            {31'd0, vecs[i].exp_we & vecs[i].wdata});
      @(negedge clk);
      tag_req = 1'b0;
      #1;
      check($sformatf("vec%0d_rvalid", i), {31'd0, tag_rvalid}, 1);
      check($sformatf("vec%0d_err", i), {31'd0, tag_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_rdata", i), {31'd0, tag_rdata}, {31'd0, vecs[i].exp_rdata});
    end

    // Back-to-back write 1, write 0, read at the same granule
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tag_req = 1'b1; tag_addr = 32'h0010_0008;
      tag_we = (k < 2); tag_wdata = (k == 0);
      #1;
      check($sformatf("b2b%0d_gnt", k), {31'd0, tag_gnt}, 1);
      if (k > 0) check($sformatf("b2b%0d_prev_rvalid", k), {31'd0, tag_rvalid}, 1);
    end
    @(negedge clk);
    tag_req = 1'b0;
    #1;
    check("b2b_read_rvalid", {31'd0, tag_rvalid}, 1);
    check("b2b_read_rdata", {31'd0, tag_rdata}, 0);
    check("b2b_read_err", {31'd0, tag_err}, 0);
    @(negedge clk);
    #1 check("b2b_idle_rvalid", {31'd0, tag_rvalid}, 0);

    // Range clears
    @(negedge clk); run_clear(32'd5, 32'd8, 1'b1);
    @(negedge clk); run_clear(32'd10, 32'd3, 1'b0);
    @(negedge clk); run_clear(32'd4090, 32'd5000, 1'b0);
    check("clr_clip_last", wr_q.size() > 0 ? wr_q[$] : -1, 4095);

    // Reset in the middle of a 5..8 sweep, once index 6 has been written
    @(negedge clk);
    tag_mem[8] = 1'b1;
    clear_start = 1'b1; clear_lo = 32'd5; clear_hi = 32'd8;
    @(negedge clk);
    clear_start = 1'b0;
    #1 check("mid_wr5", tmem_addr, 5);
    @(negedge clk);
    #1 check("mid_wr6", tmem_addr, 6);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_busy", {31'd0, clear_busy}, 0);
    check("mid_rst_done", {31'd0, clear_done}, 0);
    check("mid_rst_tmem_we", {31'd0, tmem_we}, 0);
    check("mid_rst_tmem_addr", tmem_addr, 0);
    check("mid_rst_rvalid", {31'd0, tag_rvalid}, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1 if (tmem_we || clear_done || clear_busy) bad++;
    end
    check("mid_rst_quiet", bad, 0);
    check("mid_rst_idx8_kept", {31'd0, tag_mem[8]}, 1);

    // Full clear brings memory and model into a known common state
    @(negedge clk); run_clear(32'd0, 32'd4095, 1'b0);

    // Randomized traffic against the reference model
    exp_pend = 1'b0; exp_err = 1'b0; exp_rd = 1'b0; mis = 0;
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      if (exp_pend) begin
        if (tag_rvalid !== 1'b1 || tag_err !== exp_err || tag_rdata !== exp_rd) begin
          mis++;
          $display("FAIL rand_resp it%0d: rvalid %0b err %0b rdata %0b expected 1 %0b %0b",
                   it, tag_rvalid, tag_err, tag_rdata, exp_err, exp_rd);
        end
      end else if (tag_rvalid !== 1'b0) begin
        mis++;
        $display("FAIL rand_idle it%0d: rvalid %0b expected 0", it, tag_rvalid);
      end
      exp_pend = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        tag_req = 1'b0;
        if ($urandom_range(0, 3) == 0) run_clear($urandom_range(4080, 4095), $urandom_range(4085, 6000), 1'b0);
        else run_clear($urandom_range(0, 70), $urandom_range(0, 80), 1'b0);
      end else if (r < 75) begin
        tag_req = 1'b1; tag_we = $urandom_range(0, 1); tag_wdata = $urandom_range(0, 1);
        case ($urandom_range(0, 4))
          0: tag_addr = BASE + 32'($urandom_range(4090, 4100)) * 8 + 32'($urandom_range(0, 7));
          1: tag_addr = $urandom;
          default: tag_addr = BASE + 32'($urandom_range(0, 63)) * 8 + 32'($urandom_range(0, 7));
        endcase
        in_r = (tag_addr >= BASE) && ((tag_addr - BASE) / 8 < SIZE);
        idx = (tag_addr - BASE) / 8;
        #1;
        if (tag_gnt !== 1'b1) mis++;
        if (in_r && (tmem_addr !== idx || tmem_we !== tag_we)) mis++;
        if (!in_r && tmem_we !== 1'b0) mis++;
        exp_pend = 1'b1;
        exp_err = !in_r;
        exp_rd = in_r && !tag_we && model_mem[idx[11:0]];
        if (in_r && tag_we) model_mem[idx[11:0]] = tag_wdata;
      end else begin
        tag_req = 1'b0;
        #1 if (tag_gnt !== 1'b0 || tmem_we !== 1'b0) mis++;
      end
    end
    @(negedge clk);
    tag_req = 1'b0;
    if (exp_pend && (tag_rvalid !== 1'b1 || tag_err !== exp_err || tag_rdata !== exp_rd)) mis++;
    check("rand_mismatches", mis, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibex_cheri_tag_ctrl.md
IBEX_CHERI_TAG_CTRL -- requirements
Module: ibex_cheri_tag_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 - TAG_MEM_SIZE, 4096, number of tag bits in the tag memory.
 - TAG_BASE_ADDR, 32'h0010_0000, byte address of tag index 0.
 - CAP_BYTES_LOG2, 3, log2 of bytes per tag granule (8-byte capability).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 - clk_i  in  1  clock.
 - rst_ni  in  1  reset, synchronous, active-low.
 - tag_req_i  in  1  LSU tag request.
 - tag_gnt_o  out  1  request accepted this cycle.
 - tag_we_i  in  1  1 = write, 0 = read.
 - tag_addr_i  in  32  byte address.
 - tag_wdata_i  in  1  tag to write (0 for plain data stores).
 - tag_rvalid_o  out  1  response valid.
 - tag_rdata_o  out  1  read tag (0 on writes/errors).
 - tag_err_o  out  1  address outside tag range, qualified by rvalid.
 - clear_start_i  in  1  start range clear, single-cycle pulse.
 - clear_lo_i  in  32  first tag index to clear.
 - clear_hi_i  in  32  last tag index to clear (inclusive).
 - clear_busy_o  out  1  sweep in progress.
 - clear_done_o  out  1  one-cycle pulse at sweep end.
 - tmem_addr_o  out  32  tag memory index.
 - tmem_we_o  out  1  tag memory write enable.
 - tmem_wdata_o  out  1  tag memory write data.
 - tmem_rdata_i  in  1  tag memory read data, valid one cycle after the address is presented.

Function
REQ-003 Index SHALL be computed as (tag_addr_i - TAG_BASE_ADDR) >> CAP_BYTES_LOG2 using 32-bit unsigned arithmetic; the address is in range iff tag_addr_i >= TAG_BASE_ADDR and index < TAG_MEM_SIZE.
REQ-004 The FSM SHALL have three states: IDLE, RESP and CLEAR.
 - IDLE -> RESP on grant.
 - RESP -> RESP on a back-to-back grant.
 - RESP -> IDLE with no grant.
 - IDLE/RESP -> CLEAR on an accepted clear.
 - CLEAR -> IDLE after the last index is written.
REQ-005 tag_gnt_o SHALL equal tag_req_i in IDLE and RESP, and SHALL be 0 in CLEAR or when clear_start_i is accepted in the same cycle.
REQ-006 On grant of an in-range request, the block SHALL drive tmem_addr_o=index, tmem_we_o=tag_we_i and tmem_wdata_o=tag_wdata_i in that same cycle.
REQ-007 On grant of an out-of-range request, the block SHALL keep tmem_we_o=0.
REQ-008 Every granted request SHALL produce exactly one response: tag_rvalid_o=1 in the cycle after grant.
 - Reads in range: tag_rdata_o=tmem_rdata_i.
 - Writes or out-of-range: tag_rdata_o=0.
 - tag_err_o=1 iff out of range.
REQ-009 Responses SHALL return in grant order, with one outstanding request maximum; throughput is one request per cycle.
REQ-010 clear_start_i SHALL be accepted in IDLE, or in RESP with no grant that cycle; it SHALL be ignored in CLEAR.
REQ-011 In CLEAR, the block SHALL write 0 to one index per cycle, from clear_lo_i to min(clear_hi_i, TAG_MEM_SIZE-1) inclusive, with both bounds latched at accept.
REQ-012 clear_busy_o SHALL be 1 from the cycle after accept through the last write cycle; clear_done_o SHALL pulse in the cycle after the last write.
REQ-013 If lo > clipped hi, the block SHALL perform no writes, enter CLEAR for one cycle, then pulse clear_done_o.
REQ-014 A pending RESP response SHALL still be delivered in the cycle CLEAR begins.
REQ-015 tmem_* outputs SHALL be 0 when not driven by REQ-006 or REQ-011.

Reset
REQ-016 When rst_ni=0 at a clock edge, the block SHALL enter state IDLE and drive tag_gnt_o, tag_rvalid_o, tag_rdata_o, tag_err_o, clear_busy_o, clear_done_o, tmem_we_o, tmem_wdata_o and tmem_addr_o to 0.
REQ-017 Reset during RESP or CLEAR SHALL drop the in-flight response and abort the sweep without asserting clear_done_o.

Structure
REQ-018 The constants CAP_BYTES_LOG2, TAG_BASE_ADDR and the FSM state enum SHALL reside in the shared package ibex_cheri_pkg.
REQ-019 The block SHALL be a single module with no sub-modules; it instantiates alongside ibex_cheri_tag_mem.

Verification
REQ-020 Test: read of 0x0010_0010 with the mem bit at index 2 = 1 -> tmem_addr_o=2 at grant; next cycle rvalid=1, rdata=1, err=0.
REQ-021 Test: writes to 0x0010_0008 (data 1) and 0x0010_0008 (data 0) back-to-back, then a read -> three grants on consecutive cycles; the read returns 0.
REQ-022 Test: request to 0x000F_FFF8 and to 0x0010_8000 -> tmem_we_o=0; rvalid=1, err=1, rdata=0.
REQ-023 Test: clear with lo=5, hi=8 -> writes to indices 5,6,7,8 on four consecutive cycles; busy=1 for 4 cycles; done pulses on the 5th cycle; tag_req_i held high is not granted until IDLE.
REQ-024 Test: clear with lo=10, hi=3 -> no writes; done pulses 2 cycles after start. Clear with hi=5000 -> last write is to 4095.
REQ-025 Test: reset asserted mid-sweep at index 6 of 5..8 -> no further writes, done never pulses, all outputs 0.
